arbiter_for_mem_rr: RTL and testbench

Parametrised successor to the three-way memory arbiter: arbitrates N_REQ requesters for the single memory port. Supports fixed-priority and round-robin modes and holds each grant until the memory signals completion. An optional watchdog force-releases a grant when memory never completes. Sits between the cache/download request sources and the memory controller in each core's memory path.

---
 rtl/arbiter_for_mem_rr_pkg.sv | 7 +
 rtl/arbiter_for_mem_rr_if.sv | 12 +
 rtl/arbiter_for_mem_rr_rr_pick.sv | 18 +
 rtl/arbiter_for_mem_rr.sv | 63 ++++++
 tb/tb_arbiter_for_mem_rr.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/arbiter_for_mem_rr_pkg.sv
// arbiter_mem_pkg: shared FSM encodings and default requester indices for the memory arbiter
package arbiter_mem_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int MEM_DL  = 0;
  localparam int DC_AREG = 1;
  localparam int IC_AREG = 2;
endpackage

// File: rtl/arbiter_for_mem_rr_if.sv
// arbiter_for_mem_rr_if: requester/memory handshake bundle for the memory arbiter
interface arbiter_for_mem_rr_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0] v_req;
  logic [N_REQ-1:0] v_grant_m;
  logic [N_REQ-1:0] ack;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic mem_access_done;
  logic busy;
  logic timeout_err;
  modport master (output v_req, mem_access_done, input v_grant_m, ack, grant_id, busy, timeout_err);
  modport slave (input v_req, mem_access_done, output v_grant_m, ack, grant_id, busy, timeout_err);
endinterface

// File: rtl/arbiter_for_mem_rr_rr_pick.sv
// rr_pick: first set request at or after base, wrapping past N_REQ-1 back to 0
module rr_pick #(parameter int N_REQ = 3) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] base,
  output logic [$clog2(N_REQ)-1:0] win,
  output logic                     found
);
  localparam int IW = $clog2(N_REQ);
  function automatic logic [IW-1:0] wrap(input int s);
    return IW'(s >= N_REQ ? s - N_REQ : s);
  endfunction
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[wrap(int'(base) + i)]) win = wrap(int'(base) + i);
  end
  assign found = |req;
endmodule

// File: rtl/arbiter_for_mem_rr.sv
// arbiter_for_mem_rr: fixed/round-robin arbiter holding the memory port until done or watchdog release
module arbiter_for_mem_rr
  import arbiter_mem_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  arbiter_for_mem_rr_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;
  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, grant_id, win, id_inc;
  logic [N_REQ-1:0] v_grant_m;
  logic [CW-1:0] cnt;
  logic found, done, wd_fire;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.v_req), .base(RR_EN ? ptr : IW'(0)), .win(win), .found(found)
  );
  assign done = state == GRANT && bus.mem_access_done;
  // done in the same cycle as the last watchdog tick takes precedence
  assign wd_fire = (TIMEOUT > 0) && state == GRANT && !bus.mem_access_done && cnt == CNT_LAST;
  assign id_inc = grant_id == IW'(N_REQ - 1) ? IW'(0) : grant_id + 1'b1;
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    state_nx = state == IDLE ? (found ? GRANT : IDLE) : (done || wd_fire ? IDLE : GRANT);
    ptr_nx = RR_EN && (done || wd_fire) ? id_inc : ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      v_grant_m <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      if (state == IDLE && found) begin
        v_grant_m <= N_REQ'(1) << win;
        grant_id <= win;
        cnt <= '0;
      end else if (state_nx == IDLE) begin
        v_grant_m <= '0;
        grant_id <= '0;
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.v_grant_m = v_grant_m;
  assign bus.grant_id = grant_id;
  assign bus.busy = state == GRANT;
  assign bus.ack = rst ? '0 : v_grant_m & {N_REQ{bus.mem_access_done}};
  assign bus.timeout_err = wd_fire & ~rst;
endmodule

// File: tb/tb_arbiter_for_mem_rr.sv
// tb_arbiter_for_mem_rr: vector table, corner sequences and randomized model check of the memory arbiter
module tb_arbiter_for_mem_rr;
  logic clk = 1'b0;
  logic [3:0] rst = '1;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  arbiter_for_mem_rr_if #(.N_REQ(3)) ifa ();
  arbiter_for_mem_rr_if #(.N_REQ(3)) ifb ();
  arbiter_for_mem_rr_if #(.N_REQ(3)) ifc ();
  arbiter_for_mem_rr_if #(.N_REQ(5)) ifd ();
  arbiter_for_mem_rr #(.N_REQ(3), .RR_EN(1), .TIMEOUT(0)) dut_a (.clk(clk), .rst(rst[0]), .bus(ifa));
  arbiter_for_mem_rr #(.N_REQ(3), .RR_EN(0), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst[1]), .bus(ifb));
  arbiter_for_mem_rr #(.N_REQ(3), .RR_EN(1), .TIMEOUT(5)) dut_c (.clk(clk), .rst(rst[2]), .bus(ifc));
  arbiter_for_mem_rr #(.N_REQ(5), .RR_EN(1), .TIMEOUT(6)) dut_d (.clk(clk), .rst(rst[3]), .bus(ifd));
  typedef struct {
    logic r; logic [2:0] req; logic d; logic [2:0] g; logic [2:0] a; logic b; logic [1:0] id;
  } vec_t;
  vec_t tab[$];
  int owner, age, mptr, gid;
  int waits[5];
  logic [4:0] pend, eg, ea;
  logic d5, eto, prev_busy;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic add(input int n, input logic r, input logic [2:0] req, input logic d,
                     input logic [2:0] g, input logic [2:0] a, input logic b, input logic [1:0] id);
    for (int i = 0; i < n; i++) tab.push_back(vec_t'{r, req, d, g, a, b, id});
  endtask
  initial begin
    {ifa.v_req, ifb.v_req, ifc.v_req, ifd.v_req} = '0;
    {ifa.mem_access_done, ifb.mem_access_done, ifc.mem_access_done, ifd.mem_access_done} = '0;
    add(1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b000, 1, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    add(3, 0, 3'b111, 0, 3'b001, 3'b000, 1, 0);
    add(1, 0, 3'b111, 1, 3'b001, 3'b001, 1, 0);
    add(1, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    add(3, 0, 3'b111, 0, 3'b010, 3'b000, 1, 1);
    add(1, 0, 3'b111, 1, 3'b010, 3'b010, 1, 1);
    add(1, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    add(3, 0, 3'b111, 0, 3'b100, 3'b000, 1, 2);
    add(1, 0, 3'b111, 1, 3'b100, 3'b100, 1, 2);
    add(1, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b111, 0, 3'b001, 3'b000, 1, 0);
    add(1, 0, 3'b111, 1, 3'b001, 3'b001, 1, 0);
    add(1, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b111, 0, 3'b010, 3'b000, 1, 1);
    add(1, 1, 3'b111, 1, 3'b010, 3'b000, 1, 1);
    add(1, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b111, 0, 3'b001, 3'b000, 1, 0);
    add(1, 0, 3'b111, 1, 3'b001, 3'b001, 1, 0);
    add(1, 0, 3'b001, 0, 3'b000, 3'b000, 0, 0);
    add(3, 0, 3'b001, 0, 3'b001, 3'b000, 1, 0);
    add(1, 0, 3'b001, 1, 3'b001, 3'b001, 1, 0);
    add(1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0);
    tick;
    tick;
    foreach (tab[i]) begin
      tick;
      rst[0] = tab[i].r;
      ifa.v_req = tab[i].req;
      ifa.mem_access_done = tab[i].d;
      #1;
      chk($sformatf("a_grant[%0d]", i), ifa.v_grant_m, tab[i].g);
      chk($sformatf("a_ack[%0d]", i), ifa.ack, tab[i].a);
      chk($sformatf("a_busy[%0d]", i), ifa.busy, tab[i].b);
      chk($sformatf("a_id[%0d]", i), ifa.grant_id, tab[i].id);
      chk($sformatf("a_timeout[%0d]", i), ifa.timeout_err, 0);
    end
    for (int r = 0; r < 3; r++) begin
      tick;
      rst[1] = 0;
      ifb.v_req = 3'b110;
      ifb.mem_access_done = 0;
      #1;
      chk("b_bubble", ifb.v_grant_m, 3'b000);
      chk("b_busy", ifb.busy, 0);
      tick;
      #1;
      chk("b_grant", ifb.v_grant_m, 3'b010);
      tick;
      ifb.mem_access_done = 1;
      #1;
      chk("b_ack", ifb.ack, 3'b010);
    end
    tick;
    ifb.v_req = 3'b100;
    ifb.mem_access_done = 0;
    #1;
    chk("b_bubble2", ifb.v_grant_m, 3'b000);
    tick;
    #1;
    chk("b_grant2", ifb.v_grant_m, 3'b100);
    chk("b_id2", ifb.grant_id, 2);
    tick;
    ifb.mem_access_done = 1;
    #1;
    chk("b_ack2", ifb.ack, 3'b100);
    tick;
    ifb.v_req = 0;
    ifb.mem_access_done = 0;
    tick;
    rst[2] = 0;
    ifc.v_req = 3'b111;
    #1;
    chk("c_idle", ifc.v_grant_m, 3'b000);
    for (int i = 1; i <= 5; i++) begin
      tick;
      #1;
      chk("c_grant0", ifc.v_grant_m, 3'b001);
      chk("c_ack0", ifc.ack, 3'b000);
      chk("c_timeout", ifc.timeout_err, i == 5);
    end
    tick;
    #1;
    chk("c_bubble", ifc.v_grant_m, 3'b000);
    chk("c_timeout_bubble", ifc.timeout_err, 0);
    for (int i = 1; i <= 5; i++) begin
      tick;
      ifc.mem_access_done = i == 5;
      #1;
      chk("c_grant1", ifc.v_grant_m, 3'b010);
      chk("c_ack1", ifc.ack, i == 5 ? 3'b010 : 3'b000);
      chk("c_timeout_tie", ifc.timeout_err, 0);
    end
    tick;
    ifc.mem_access_done = 0;
    #1;
    chk("c_bubble2", ifc.busy, 0);
    tick;
    #1;
    chk("c_grant2", ifc.v_grant_m, 3'b100);
    chk("c_id2", ifc.grant_id, 2);
    owner = -1;
    age = 0;
    mptr = 0;
    pend = '0;
    prev_busy = 0;
    foreach (waits[i]) waits[i] = 0;
    repeat (10000) begin
      tick;
      rst[3] = 0;
      for (int i = 0; i < 5; i++) if (!pend[i] && $urandom_range(3) == 0) pend[i] = 1'b1;
      d5 = owner >= 0 ? $urandom_range(4) == 0 : $urandom_range(7) == 0;
      ifd.v_req = pend;
      ifd.mem_access_done = d5;
      #1;
      eg = owner >= 0 ? 5'(1) << owner : 5'b0;
      ea = d5 ? eg : 5'b0;
      eto = owner >= 0 && !d5 && age == 5;
      chk("d_grant", ifd.v_grant_m, eg);
      chk("d_ack", ifd.ack, ea);
      chk("d_timeout", ifd.timeout_err, eto);
      chk("d_busy", ifd.busy, owner >= 0);
      chk("d_onehot", $onehot0(ifd.v_grant_m), 1);
      if (ifd.busy && !prev_busy && ifd.grant_id < 5) begin
        gid = int'(ifd.grant_id);
        chk("d_wait", waits[gid] > 5, 0);
        waits[gid] = 0;
        for (int i = 0; i < 5; i++) if (i != gid && pend[i]) waits[i]++;
      end
      prev_busy = ifd.busy;
      if (owner >= 0) begin
        if (d5 || eto) begin
          mptr = (owner + 1) % 5;
          owner = -1;
        end else age++;
      end else if (pend != 0) begin
        for (int k = 4; k >= 0; k--) if (pend[(mptr + k) % 5]) owner = (mptr + k) % 5;
        age = 0;
      end
      pend &= ~ea;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
